// File: rtl/imm_enc_if.sv
// Request/response bundle for imm_encoder.
// master drives requests and out_ready; slave is the encoder.
interface imm_enc_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  imm_src;
    logic [31:0] imm;
    logic [31:0] base_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic        out_err;

    modport master (
        output in_valid,
        output imm_src,
        output imm,
        output base_instr,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  instr,
        input  out_err
    );

    modport slave (
        input  in_valid,
        input  imm_src,
        input  imm,
        input  base_instr,
        input  out_ready,
        output in_ready,
        output out_valid,
        output instr,
        output out_err
    );
endinterface

// File: rtl/imm_encoder.sv
// Scatters an immediate into RV32I I/S/B/J/U bit positions over base_instr.
// Two-stage valid/ready pipeline with full backpressure.
// Ports: clk, reset (sync, active-high), bus (imm_enc_if.slave:
//   in_valid/in_ready/imm_src/imm/base_instr, out_valid/out_ready/instr/out_err),
//   enc_count (completed output handshakes, wraps).
// Optional macro IMM_ENC_RANGE_CHECK_EN enables out_err range/alignment checks;
// without it out_err is tied to 0 and no check logic exists.
module imm_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    imm_enc_if.slave         bus,
    output logic [CNT_W-1:0] enc_count
);

    localparam logic [2:0] SRC_I = 3'b000;
    localparam logic [2:0] SRC_S = 3'b001;
    localparam logic [2:0] SRC_B = 3'b010;
    localparam logic [2:0] SRC_J = 3'b011;
    localparam logic [2:0] SRC_U = 3'b100;

    logic             s1_valid_q, s1_valid_d;
    logic [2:0]       s1_src_q, s1_src_d;
    logic [31:0]      s1_imm_q, s1_imm_d;
    logic [31:0]      s1_base_q, s1_base_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      instr_q, instr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        s1_adv;
    logic        in_rdy;
    logic        s1_load;
    logic        s2_load;
    logic [31:0] instr_enc;

    // Stage 1 moves on whenever stage 2 is empty or draining this cycle.
    assign s1_adv  = !out_valid_q || bus.out_ready;
    assign in_rdy  = !s1_valid_q || s1_adv;
    assign s1_load = bus.in_valid && in_rdy;
    assign s2_load = s1_valid_q && s1_adv;

    always_comb begin
        instr_enc = s1_base_q;
        unique case (s1_src_q)
            SRC_I: begin
                instr_enc[31:20] = s1_imm_q[11:0];
            end
            SRC_S: begin
                instr_enc[31:25] = s1_imm_q[11:5];
                instr_enc[11:7]  = s1_imm_q[4:0];
            end
            SRC_B: begin
                instr_enc[31]    = s1_imm_q[12];
                instr_enc[30:25] = s1_imm_q[10:5];
                instr_enc[11:8]  = s1_imm_q[4:1];
                instr_enc[7]     = s1_imm_q[11];
            end
            SRC_J: begin
                instr_enc[31]    = s1_imm_q[20];
                instr_enc[30:21] = s1_imm_q[10:1];
                instr_enc[20]    = s1_imm_q[11];
                instr_enc[19:12] = s1_imm_q[19:12];
            end
            SRC_U: begin
                instr_enc[31:12] = s1_imm_q[31:12];
            end
            default: begin
                instr_enc = s1_base_q;
            end
        endcase
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_src_d    = s1_src_q;
        s1_imm_d    = s1_imm_q;
        s1_base_d   = s1_base_q;
        out_valid_d = out_valid_q;
        instr_d     = instr_q;
        cnt_d       = cnt_q;
        if (in_rdy) begin
            s1_valid_d = bus.in_valid;
        end
        if (s1_load) begin
            s1_src_d  = bus.imm_src;
            s1_imm_d  = bus.imm;
            s1_base_d = bus.base_instr;
        end
        if (s1_adv) begin
            out_valid_d = s1_valid_q;
        end
        if (s2_load) begin
            instr_d = instr_enc;
        end
        if (out_valid_q && bus.out_ready) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_src_q    <= 3'b000;
            s1_imm_q    <= 32'h0;
            s1_base_q   <= 32'h0;
            out_valid_q <= 1'b0;
            instr_q     <= 32'h0;
            cnt_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_src_q    <= s1_src_d;
            s1_imm_q    <= s1_imm_d;
            s1_base_q   <= s1_base_d;
            out_valid_q <= out_valid_d;
            instr_q     <= instr_d;
            cnt_q       <= cnt_d;
        end
    end

`ifdef IMM_ENC_RANGE_CHECK_EN
    localparam logic signed [31:0] IS_MIN = -32'sd2048;
    localparam logic signed [31:0] IS_MAX = 32'sd2047;
    localparam logic signed [31:0] B_MIN  = -32'sd4096;
    localparam logic signed [31:0] B_MAX  = 32'sd4094;
    localparam logic signed [31:0] J_MIN  = -32'sd1048576;
    localparam logic signed [31:0] J_MAX  = 32'sd1048574;

    logic               err_chk;
    logic signed [31:0] simm;
    logic               s1_err_q, s1_err_d;
    logic               err_q, err_d;

    assign simm = bus.imm;

    // Checked on the raw request so the flag travels with its data.
    always_comb begin
        err_chk = 1'b0;
        unique case (bus.imm_src)
            SRC_I, SRC_S: err_chk = (simm < IS_MIN) || (simm > IS_MAX);
            SRC_B: err_chk = (simm < B_MIN) || (simm > B_MAX) || bus.imm[0];
            SRC_J: err_chk = (simm < J_MIN) || (simm > J_MAX) || bus.imm[0];
            SRC_U: err_chk = (bus.imm[11:0] != 12'h000);
            default: err_chk = 1'b1;
        endcase
    end

    always_comb begin
        s1_err_d = s1_err_q;
        err_d    = err_q;
        if (s1_load) begin
            s1_err_d = err_chk;
        end
        if (s2_load) begin
            err_d = s1_err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_err_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            s1_err_q <= s1_err_d;
            err_q    <= err_d;
        end
    end

    assign bus.out_err = err_q;
`else
    assign bus.out_err = 1'b0;
`endif

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_valid_q;
    assign bus.instr     = instr_q;
    assign enc_count     = cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed table, backpressure,
// mid-flight reset and randomized traffic against a reference model.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] enc_count;
    int          checks = 0;
    int          errors = 0;

    imm_enc_if bus ();

    imm_encoder #(.CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .enc_count (enc_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  src;
        logic [31:0] imm;
        logic [31:0] base;
        logic [31:0] instr;
        logic        err;
    } vec_t;

    vec_t tv[12];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference: place immediate fields with shifts/masks from the ISA layout.
    function automatic logic [31:0] ref_enc(input logic [2:0] src,
                                            input logic [31:0] imm,
                                            input logic [31:0] base);
        case (src)
            3'd0: return (base & 32'h000FFFFF) | ((imm & 32'hFFF) << 20);
            3'd1: return (base & 32'h01FFF07F) | (((imm >> 5) & 32'h7F) << 25)
                         | ((imm & 32'h1F) << 7);
            3'd2: return (base & 32'h01FFF07F) | (((imm >> 12) & 32'h1) << 31)
                         | (((imm >> 5) & 32'h3F) << 25)
                         | (((imm >> 1) & 32'hF) << 8)
                         | (((imm >> 11) & 32'h1) << 7);
            3'd3: return (base & 32'h00000FFF) | (((imm >> 20) & 32'h1) << 31)
                         | (((imm >> 1) & 32'h3FF) << 21)
                         | (((imm >> 11) & 32'h1) << 20)
                         | (imm & 32'h000FF000);
            3'd4: return (base & 32'h00000FFF) | (imm & 32'hFFFFF000);
            default: return base;
        endcase
    endfunction

    function automatic logic ref_err(input logic [2:0] src,
                                     input logic [31:0] imm);
        int s;
        s = int'(imm);
`ifdef IMM_ENC_RANGE_CHECK_EN
        case (src)
            3'd0, 3'd1: return (s < -2048) || (s > 2047);
            3'd2: return (s < -4096) || (s > 4094) || ((s % 2) != 0);
            3'd3: return (s < -1048576) || (s > 1048574) || ((s % 2) != 0);
            3'd4: return (imm & 32'hFFF) != 0;
            default: return 1'b1;
        endcase
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic tbl_err(input logic e);
`ifdef IMM_ENC_RANGE_CHECK_EN
        return e;
`else
        return 1'b0;
`endif
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drive(input logic v, input logic [2:0] s,
                         input logic [31:0] i, input logic [31:0] b);
        bus.in_valid = v;
        bus.imm_src = s;
        bus.imm = i;
        bus.base_instr = b;
    endtask

    task automatic run_vec(input int k);
        string nm;
        nm = $sformatf("vec%0d", k);
        @(negedge clk);
        drive(1'b1, tv[k].src, tv[k].imm, tv[k].base);
        bus.out_ready = 1'b1;
        #1;
        chk({nm, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        chk({nm, "_early"}, 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        #1;
        chk({nm, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({nm, "_instr"}, bus.instr, tv[k].instr);
        chk({nm, "_err"}, 32'(bus.out_err), 32'(tbl_err(tv[k].err)));
        @(posedge clk);
    endtask

    logic [31:0] qi[$];
    logic        qe[$];
    logic [2:0]  rs[3];
    logic [31:0] ri[3];
    int          idx, got, seen, cnt_model;
    logic        acc, stall_prev;
    logic [31:0] prev_instr;
    logic        prev_err;
    logic [31:0] ei;
    logic        ee;

    initial begin
        tv[0]  = '{3'd0, 32'hFFFFFFFF, 32'h00000013, 32'hFFF00013, 1'b0};
        tv[1]  = '{3'd2, 32'hFFFFFFFC, 32'h00000063, 32'hFE000EE3, 1'b0};
        tv[2]  = '{3'd3, 32'h00000008, 32'h0000006F, 32'h0080006F, 1'b0};
        tv[3]  = '{3'd4, 32'h12345000, 32'h00000037, 32'h12345037, 1'b0};
        tv[4]  = '{3'd0, 32'h00000800, 32'h00000013, 32'h80000013, 1'b1};
        tv[5]  = '{3'd2, 32'h00000006, 32'h00000063, 32'h00000363, 1'b0};
        tv[6]  = '{3'd2, 32'h00000005, 32'h00000063, 32'h00000263, 1'b1};
        tv[7]  = '{3'd5, 32'h12345678, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1};
        tv[8]  = '{3'd1, 32'hFFFFF800, 32'h00000023, 32'h80000023, 1'b0};
        tv[9]  = '{3'd3, 32'hFFF00000, 32'h0000006F, 32'h8000006F, 1'b0};
        tv[10] = '{3'd3, 32'h00100000, 32'h0000006F, 32'h8000006F, 1'b1};
        tv[11] = '{3'd4, 32'h00000001, 32'h00000037, 32'h00000037, 1'b1};

        reset = 1'b1;
        drive(1'b0, 3'd0, 32'h0, 32'h0);
        bus.out_ready = 1'b0;
        do_reset();
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_instr", bus.instr, 32'h0);
        chk("rst_err", 32'(bus.out_err), 32'd0);
        chk("rst_count", 32'(enc_count), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        for (int k = 0; k < 12; k++) run_vec(k);

        // Backpressure: stalled output, three requests offered.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            rs[k] = 3'd0;
            ri[k] = 32'(k + 1);
        end
        idx = 0;
        acc = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            drive(1'b1, rs[idx], ri[idx], 32'h00000013);
            #1;
            acc = bus.in_ready;
            @(posedge clk);
            if (acc) idx++;
        end
        chk("bp_accepted", 32'(idx), 32'd2);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_hold_instr", bus.instr,
                ref_enc(rs[0], ri[0], 32'h00000013));
        end
        got = 0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            drive(idx < 3, rs[idx % 3], ri[idx % 3], 32'h00000013);
            #1;
            if (bus.out_valid) begin
                chk("bp_order", bus.instr,
                    ref_enc(rs[got], ri[got], 32'h00000013));
                got++;
            end
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            if (acc) idx++;
        end
        chk("bp_drained", 32'(got), 32'd3);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        chk("bp_count", 32'(enc_count), 32'd3);

        // Reset while both stages hold data.
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(1'b1, 3'd4, 32'hABCDE000, 32'h00000037);
        end
        @(negedge clk);
        #1;
        chk("mf_full", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mf_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mf_count", 32'(enc_count), 32'd0);
        chk("mf_in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        chk("mf_no_stale", 32'(seen), 32'd0);

        // Randomized traffic against the reference model.
        do_reset();
        cnt_model = 0;
        stall_prev = 1'b0;
        prev_instr = 32'h0;
        prev_err = 1'b0;
        for (int c = 0; c < 600; c++) begin
            logic [31:0] rimm;
            @(negedge clk);
            case ($urandom % 4)
                0: rimm = $urandom;
                1: rimm = 32'($urandom_range(0, 8191)) - 32'd4096;
                2: rimm = $urandom << 12;
                default: rimm = 32'($urandom_range(0, 4194303)) - 32'd2097152;
            endcase
            drive(($urandom % 4) != 0, 3'($urandom_range(0, 7)), rimm,
                  $urandom);
            bus.out_ready = ($urandom % 3) != 0;
            #1;
            if (stall_prev) begin
                chk("rnd_stable_valid", 32'(bus.out_valid), 32'd1);
                chk("rnd_stable_instr", bus.instr, prev_instr);
                chk("rnd_stable_err", 32'(bus.out_err), 32'(prev_err));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (qi.size() == 0) begin
                    chk("rnd_spurious", 32'd1, 32'd0);
                end else begin
                    ei = qi.pop_front();
                    ee = qe.pop_front();
                    chk("rnd_instr", bus.instr, ei);
                    chk("rnd_err", 32'(bus.out_err), 32'(ee));
                end
                cnt_model++;
            end
            if (bus.in_valid && bus.in_ready) begin
                qi.push_back(ref_enc(bus.imm_src, bus.imm, bus.base_instr));
                qe.push_back(ref_err(bus.imm_src, bus.imm));
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            prev_instr = bus.instr;
            prev_err = bus.out_err;
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.out_ready = 1'b1;
            #1;
            if (bus.out_valid) begin
                if (qi.size() == 0) begin
                    chk("drain_spurious", 32'd1, 32'd0);
                end else begin
                    ei = qi.pop_front();
                    ee = qe.pop_front();
                    chk("drain_instr", bus.instr, ei);
                    chk("drain_err", 32'(bus.out_err), 32'(ee));
                end
                cnt_model++;
            end
        end
        chk("rnd_queue_empty", 32'(qi.size()), 32'd0);
        @(negedge clk);
        #1;
        chk("rnd_count", 32'(enc_count), 32'(cnt_model & 16'hFFFF));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
